// File: rtl/hpdmc_pkg.sv
// Shared HPDMC control-interface definitions: CSR register map, command/control
// bit positions and the init sequencer state encoding.
package hpdmc_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CMD  = 2'd1;
  localparam logic [1:0] REG_TIM  = 2'd2;
  localparam logic [1:0] REG_IDLY = 2'd3;

  localparam int CMD_CS  = 0;
  localparam int CMD_WE  = 1;
  localparam int CMD_CAS = 2;
  localparam int CMD_RAS = 3;
  localparam int CMD_ADR = 4;
  localparam int CMD_BA  = 17;

  localparam int CTRL_BYPASS = 0;
  localparam int CTRL_RST    = 1;
  localparam int CTRL_CKE    = 2;

  typedef enum logic [3:0] {
    S_IDLE, S_PWR, S_PWAIT, S_PRE, S_REF, S_MRS, S_GAP,
    S_TIM, S_RD, S_CHK, S_RUN, S_DONE
  } init_state_e;

  function automatic logic [13:0] csr_reg_addr(input logic [3:0] page, input logic [1:0] r);
    return {page, 8'h00, r};
  endfunction

endpackage

// File: rtl/hpdmc_wait_timer.sv
// Loadable down-counter; holds at zero and flags it.
module hpdmc_wait_timer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        load_i,
  input  logic [15:0] val_i,
  input  logic        dec_i,
  output logic        zero_o
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= 16'd0;
    end else if (load_i) begin
      cnt_q <= val_i;
    end else if (dec_i && (cnt_q != 16'd0)) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign zero_o = (cnt_q == 16'd0);

endmodule

// File: rtl/hpdmc_init_seq.sv
// SDRAM power-up sequencer acting as CSR master toward the HPDMC slave;
// transparent host pass-through whenever the sequence is not running.
module hpdmc_init_seq
  import hpdmc_pkg::*;
#(
  parameter logic [3:0]  csr_addr   = 4'h0,
  parameter logic [15:0] PWRUP_WAIT = 16'd20000,
  parameter logic [15:0] CMD_WAIT   = 16'd8,
  parameter logic [3:0]  NREF       = 4'd2,
  parameter logic [12:0] MODE       = 13'h022,
  parameter logic [23:0] TIMING     = 24'h993612,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  input  logic [13:0] host_csr_a,
  input  logic        host_csr_we,
  input  logic [31:0] host_csr_di,
  output logic [31:0] host_csr_do,
  output logic [13:0] csr_a,
  output logic        csr_we,
  output logic [31:0] csr_di,
  input  logic [31:0] csr_do
);

  localparam logic [31:0] CTRL_INIT = (32'd1 << CTRL_BYPASS) | (32'd1 << CTRL_RST) | (32'd1 << CTRL_CKE);
  localparam logic [31:0] CTRL_RUN  = 32'd1 << CTRL_CKE;
  localparam logic [31:0] CMD_PRE   = (32'd1 << CMD_CS) | (32'd1 << CMD_WE) | (32'd1 << CMD_RAS)
                                    | (32'd1 << (CMD_ADR + 10));
  localparam logic [31:0] CMD_REF   = (32'd1 << CMD_CS) | (32'd1 << CMD_CAS) | (32'd1 << CMD_RAS);
  localparam logic [31:0] CMD_MRS   = (32'd1 << CMD_CS) | (32'd1 << CMD_WE) | (32'd1 << CMD_CAS)
                                    | (32'd1 << CMD_RAS) | ({19'd0, MODE} << CMD_ADR)
                                    | (32'd0 << CMD_BA);

  init_state_e state_q, state_d, prev_q;
  logic [3:0]  ref_q;
  logic        busy_q, done_q, error_q;
  logic        seq_we_q;
  logic [13:0] seq_a_q;
  logic [31:0] seq_di_q;
  logic        go;
  logic        tmr_load, tmr_zero;
  logic [15:0] tmr_val;

  // The timer is loaded on entry to a command state so it already holds N
  // during the command cycle; the following wait state then lasts N cycles.
  always_comb begin
    go       = ((state_q == S_IDLE) && (start || AUTO_START)) || ((state_q == S_DONE) && start);
    state_d  = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (go) state_d = S_PWR;
      S_PWR:          state_d = S_PWAIT;
      S_PWAIT:        if (tmr_zero) state_d = S_PRE;
      S_PRE, S_REF, S_MRS: state_d = S_GAP;
      S_GAP: begin
        if (tmr_zero) begin
          case (prev_q)
            S_PRE:   state_d = S_REF;
            S_REF:   state_d = (ref_q < NREF) ? S_REF : S_MRS;
            default: state_d = S_TIM;
          endcase
        end
      end
      S_TIM:   state_d = S_RD;
      S_RD:    state_d = S_CHK;
      S_CHK:   state_d = S_RUN;
      S_RUN:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
    tmr_load = (state_d == S_PWR) || (state_d == S_PRE) || (state_d == S_REF) || (state_d == S_MRS);
    tmr_val  = (state_d == S_PWR) ? PWRUP_WAIT : CMD_WAIT;
  end

  hpdmc_wait_timer u_timer (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst_n),
    .load_i (tmr_load),
    .val_i  (tmr_val),
    .dec_i  (busy_q),
    .zero_o (tmr_zero)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= S_IDLE;
      prev_q   <= S_IDLE;
      ref_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      seq_we_q <= 1'b0;
      seq_a_q  <= 14'd0;
      seq_di_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_PRE) || (state_q == S_REF) || (state_q == S_MRS)) prev_q <= state_q;
      if (state_d == S_PWR)      ref_q <= 4'd0;
      else if (state_q == S_REF) ref_q <= ref_q + 4'd1;
      busy_q <= (state_d != S_IDLE) && (state_d != S_DONE);
      done_q <= (state_d == S_DONE);
      if (state_d == S_PWR)                                    error_q <= 1'b0;
      else if ((state_q == S_CHK) && (csr_do[23:0] != TIMING)) error_q <= 1'b1;

      // Bus registers follow the state being entered, so each write lands
      // in the same cycle as its state.
      seq_we_q <= 1'b0;
      seq_a_q  <= 14'd0;
      seq_di_q <= 32'd0;
      case (state_d)
        S_PWR: begin seq_we_q <= 1'b1; seq_a_q <= csr_reg_addr(csr_addr, REG_CTRL); seq_di_q <= CTRL_INIT; end
        S_PRE: begin seq_we_q <= 1'b1; seq_a_q <= csr_reg_addr(csr_addr, REG_CMD);  seq_di_q <= CMD_PRE;   end
        S_REF: begin seq_we_q <= 1'b1; seq_a_q <= csr_reg_addr(csr_addr, REG_CMD);  seq_di_q <= CMD_REF;   end
        S_MRS: begin seq_we_q <= 1'b1; seq_a_q <= csr_reg_addr(csr_addr, REG_CMD);  seq_di_q <= CMD_MRS;   end
        S_TIM: begin seq_we_q <= 1'b1; seq_a_q <= csr_reg_addr(csr_addr, REG_TIM);  seq_di_q <= {8'd0, TIMING}; end
        S_RD:  seq_a_q <= csr_reg_addr(csr_addr, REG_TIM);
        S_RUN: begin seq_we_q <= 1'b1; seq_a_q <= csr_reg_addr(csr_addr, REG_CTRL); seq_di_q <= CTRL_RUN;  end
        default: ;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign csr_a       = busy_q ? seq_a_q  : host_csr_a;
  assign csr_we      = busy_q ? seq_we_q : host_csr_we;
  assign csr_di      = busy_q ? seq_di_q : host_csr_di;
  assign host_csr_do = csr_do;

endmodule

// File: tb/tb_hpdmc_init_seq.sv
// Bench for hpdmc_init_seq: expected bus traces built from the power-up recipe,
// random host traffic and start pulses during the sequence, plus reset/restart corners.
module tb_hpdmc_init_seq;

  localparam logic [15:0] PW     = 16'd10;
  localparam logic [15:0] CW     = 16'd3;
  localparam logic [12:0] MODE_V = 13'h022;
  localparam logic [23:0] TIM_V  = 24'h993612;

  typedef struct {
    logic        hwe;
    logic [13:0] ha;
    logic [31:0] hdi;
    logic        ewe;
    logic [13:0] ea;
    logic [31:0] edi;
  } vec_t;

  vec_t vec_q[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start0, start1, corrupt;
  logic [13:0] ha;
  logic        hwe;
  logic [31:0] hdi;

  logic        busy0, done0, err0, we0, busy1, done1, err1, we1;
  logic [13:0] a0, a1;
  logic [31:0] di0, di1, hdo0, hdo1, do0, do1;
  logic [31:0] sregs0 [4];
  logic [31:0] sregs1 [4];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hpdmc_init_seq #(.csr_addr(4'h0), .PWRUP_WAIT(PW), .CMD_WAIT(CW), .NREF(4'd2),
                   .MODE(MODE_V), .TIMING(TIM_V), .AUTO_START(1'b1)) dut0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start0),
    .busy(busy0), .done(done0), .error(err0),
    .host_csr_a(ha), .host_csr_we(hwe), .host_csr_di(hdi), .host_csr_do(hdo0),
    .csr_a(a0), .csr_we(we0), .csr_di(di0), .csr_do(do0));

  hpdmc_init_seq #(.csr_addr(4'h0), .PWRUP_WAIT(PW), .CMD_WAIT(CW), .NREF(4'd1),
                   .MODE(MODE_V), .TIMING(TIM_V), .AUTO_START(1'b0)) dut1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .start(start1),
    .busy(busy1), .done(done1), .error(err1),
    .host_csr_a(ha), .host_csr_we(hwe), .host_csr_di(hdi), .host_csr_do(hdo1),
    .csr_a(a1), .csr_we(we1), .csr_di(di1), .csr_do(do1));

  // Slave models: registered readback, optional bit-0 corruption on register 2.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      do0 <= 32'd0;
      do1 <= 32'd0;
    end else begin
      if (we0) sregs0[a0[1:0]] <= di0;
      if (we1) sregs1[a1[1:0]] <= di1;
      do0 <= sregs0[a0[1:0]] ^ ((corrupt && a0[1:0] == 2'd2) ? 32'h1 : 32'h0);
      do1 <= sregs1[a1[1:0]] ^ ((corrupt && a1[1:0] == 2'd2) ? 32'h1 : 32'h0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic rd, input logic [1:0] r, input logic [31:0] d);
    vec_t v;
    v.hwe = 1'($urandom_range(0, 1));
    v.ha  = 14'($urandom);
    v.hdi = $urandom;
    v.ewe = we;
    v.ea  = (we || rd) ? {4'h0, 8'h00, r} : 14'd0;
    v.edi = we ? d : 32'd0;
    vec_q.push_back(v);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) push(1'b0, 1'b0, 2'd0, 32'd0);
  endtask

  // Expected per-cycle bus activity while the sequencer owns the bus.
  task automatic build_trace(input int nref);
    vec_q.delete();
    push(1'b1, 1'b0, 2'd0, 32'h7);
    idle(int'(PW));
    push(1'b1, 1'b0, 2'd1, 32'h400B);
    idle(int'(CW));
    for (int k = 0; k < nref; k++) begin
      push(1'b1, 1'b0, 2'd1, 32'hD);
      idle(int'(CW));
    end
    push(1'b1, 1'b0, 2'd1, 32'hF + 32'(MODE_V) * 16);
    idle(int'(CW));
    push(1'b1, 1'b0, 2'd2, {8'd0, TIM_V});
    push(1'b0, 1'b1, 2'd2, 32'd0);
    idle(1);
    push(1'b1, 1'b0, 2'd0, 32'h4);
  endtask

  task automatic run_trace(input bit sel, input bit exp_err);
    int n;
    n = vec_q.size();
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ha  = vec_q[i].ha;
      hwe = vec_q[i].hwe;
      hdi = vec_q[i].hdi;
      if (sel) start1 = (i > 0 && i < n - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      else     start0 = (i > 0 && i < n - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      chk($sformatf("trace%0d[%0d] busy,done,we,a,di", sel, i),
          64'(sel ? {busy1, done1, we1, a1, di1} : {busy0, done0, we0, a0, di0}),
          64'({1'b1, 1'b0, vec_q[i].ewe, vec_q[i].ea, vec_q[i].edi}));
      chk($sformatf("hdo%0d[%0d]", sel, i), 64'(sel ? hdo1 : hdo0), 64'(sel ? do1 : do0));
    end
    ha = 14'd0; hwe = 1'b0; hdi = 32'd0; start0 = 1'b0; start1 = 1'b0;
    @(posedge clk); @(negedge clk);
    chk($sformatf("end%0d busy,done,error", sel),
        64'(sel ? {busy1, done1, err1} : {busy0, done0, err0}), 64'({1'b0, 1'b1, exp_err}));
  endtask

  initial begin
    bit found;
    logic [13:0] ra;
    logic [31:0] rd;
    logic        rw;
    for (int k = 0; k < 4; k++) begin sregs0[k] = 32'd0; sregs1[k] = 32'd0; end
    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; corrupt = 1'b0;
    ha = 14'd0; hwe = 1'b0; hdi = 32'd0;
    build_trace(2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset0", 64'({busy0, done0, err0, we0, a0, di0}), 64'd0);
    chk("reset1", 64'({busy1, done1, err1, we1, a1, di1}), 64'd0);
    rst_n = 1'b1;
    run_trace(1'b0, 1'b0);
    chk("dut1_idle", 64'({busy1, done1}), 64'd0);

    @(negedge clk);
    ha = 14'd0; hwe = 1'b1; hdi = 32'h1;
    #1 chk("pass_w0", 64'({we0, a0, di0}), 64'({1'b1, 14'd0, 32'h1}));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ra = 14'($urandom); rw = 1'($urandom_range(0, 1)); rd = $urandom;
      ha = ra; hwe = rw; hdi = rd;
      #1;
      chk($sformatf("pass0_%0d", k), 64'({we0, a0, di0}), 64'({rw, ra, rd}));
      chk($sformatf("pass1_%0d", k), 64'({we1, a1, di1}), 64'({rw, ra, rd}));
    end
    ha = 14'd0; hwe = 1'b0; hdi = 32'd0;

    corrupt = 1'b1;
    @(negedge clk) start0 = 1'b1;
    run_trace(1'b0, 1'b1);
    corrupt = 1'b0;

    @(negedge clk) start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (we0 && di0 == 32'hD) found = 1'b1;
    end
    chk("first_ref_seen", 64'(found), 64'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 chk("async_reset", 64'({busy0, done0, err0, we0, a0, di0}), 64'd0);
    chk("async_reset_do", 64'(hdo0), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    run_trace(1'b0, 1'b0);

    build_trace(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("no_auto%0d", k), 64'({busy1, done1, we1}), 64'd0);
    end
    start1 = 1'b1;
    run_trace(1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
